aurora_rx_lane: RTL and testbench
=================================

Name: aurora_rx_lane

Overview:
- Single-lane Aurora 64B/66B receive path, the far end of the transmit lane in aurora_top.
- Takes 66-bit encoded blocks, acquires block lock on sync headers, descrambles the payload, and decodes data and separator blocks.
- Rebuilds the AXI-Stream frame (valid/last/keep/data) for the user side.
- One instance per lane; bench-level loopback partner of the transmitter.

Parameters:
- ENCODED_DATA_SIZE, 66, encoded block width (2-bit header + 64-bit payload).
- AXI_DATA_SIZE, 64, user data width.
- LOCK_CNT, 64, consecutive valid headers needed to lock; also the error-window length.
- UNLOCK_ERR, 16, header errors within one window that drop lock.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- enc_valid  in  1  enc_data holds a block this cycle.
- enc_data  in  ENCODED_DATA_SIZE  [65:64] sync header, [63:0] scrambled payload; byte k = [8k+7:8k].
- axi_valid  out  1  output beat valid; no backpressure.
- axi_last  out  1  final beat of frame.
- axi_keep  out  8  byte enables, bit k covers byte k.
- axi_data  out  AXI_DATA_SIZE  user data.
- block_lock  out  1  lock FSM is in LOCK.
- hdr_err  out  1  one-cycle pulse per invalid header (00/11) while in LOCK.
- frame_err  out  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset: all outputs 0; FSM=HUNT; counters, descrambler state, hold register and in_frame cleared.
- All state advances only on cycles with enc_valid=1.
- Lock FSM:
  - HUNT: header 01/10 increments cnt; 00/11 clears cnt. At cnt==LOCK_CNT go to LOCK, with block_lock=1 on that edge. Blocks received in HUNT are not decoded.
  - LOCK: window counter counts blocks 0..LOCK_CNT-1 and wraps; err counter counts invalid headers and clears at window wrap.
  - LOCK → HUNT when err reaches UNLOCK_ERR; all counters clear. An error coinciding with the window wrap is counted before the clear.
- Descrambler: self-synchronous x^58+x^39+1. Bits are processed LSB first: out[i] = in[i] ^ s[i-39] ^ s[i-58], where s holds previously received scrambled bits. State updates with every payload, including in HUNT and on bad headers.
- Decode (LOCK, valid header only):
  - Header 01 (data): if the hold register is full, emit it (keep 0xFF, last 0). Load the new payload into hold; set in_frame.
  - Header 10, type byte0=0x78 (idle): discarded; hold register untouched.
  - Header 10, type 0x1E (separator):
    - N=byte1. N>6 → frame_err pulse, block dropped.
    - Emit hold if full (last 0 if N>0, last 1 if N==0).
    - If N>0, the next cycle emits data=payload>>16, keep=(1<<N)-1, last=1.
    - N==0 with hold empty → frame_err pulse, no beat.
    - Clear in_frame.
  - Header 10, type 0xE1 (separator-7): emit hold (last 0) if full. Next cycle emit data=payload>>8, keep 0x7F, last 1. Clear in_frame.
  - Any other control type: discarded.
- Latency: a data beat appears on the edge after the next data/separator block is accepted. A pending separator beat appears exactly one cycle later. The pending slot never collides with a new emit, because each emit frees the hold register.
- Lock loss or header error mid-frame:
  - Lock loss while in_frame=1 → hold and pending slot flushed without output, frame_err pulse, in_frame=0.
  - A header error in LOCK only drops that block.
- axi_data bytes beyond keep are 0.

Optional Feature:
- Macro: AURORA_RX_ERR_CNT_EN.
- Defined:
  - Adds ports err_cnt_clr (in, 1) and hdr_err_cnt / frame_err_cnt (out, 16 each).
  - Counters increment on each hdr_err / frame_err pulse and saturate at 0xFFFF.
  - Cleared by rst or err_cnt_clr; clear wins over a simultaneous increment.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Bench requirement: all stimulus is scrambled by a reference scrambler seeded 0, with 58 leading idle blocks before any check.
- 1. Reset, then 64 idle blocks with header 10 → block_lock rises on the edge after the 64th block; axi_valid stays 0.
- 2. Locked; send data blocks D0, D1, D2, then separator N=0 → 3 beats D0, D1, D2, all keep 0xFF, axi_last only on D2.
- 3. Locked; send D0, D1, separator N=3 with bytes AA BB CC → 3 beats; third beat data 0x0000000000CCBBAA, keep 0x07, last 1, one cycle after D1's beat.
- 4. Locked; 16 blocks with header 00 within one 64-block window → 16 hdr_err pulses; block_lock falls on the 16th; mid-frame case also gives frame_err=1 and no axi_last.
- 5. Locked, idle line; separator N=0 → frame_err single pulse, axi_valid 0; separator N=7 (0x1E) → frame_err pulse.
- 6. rst=1 for one cycle in mid-frame after D0 → all outputs 0 next edge; relock and a clean 2-beat frame are received intact. With AURORA_RX_ERR_CNT_EN defined, also check counters saturate at 0xFFFF and err_cnt_clr wins over a simultaneous increment.

Source files
------------

// File: rtl/aurora_rx_lane.sv
// aurora_rx_lane: single-lane Aurora 64B/66B receive path.
//   Acquires block lock on 2-bit sync headers, descrambles every payload
//   (self-synchronous x^58+x^39+1), decodes data/separator/idle blocks and
//   rebuilds an AXI-Stream frame. All state advances only when enc_valid=1.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   enc_valid        enc_data holds a block this cycle
//   enc_data         [65:64] sync header, [63:0] scrambled payload
//   axi_valid/last   output beat valid / final beat of frame (no backpressure)
//   axi_keep         byte enables, bit k covers byte k
//   axi_data         user data, bytes beyond keep are zero
//   block_lock       lock FSM is in LOCK
//   hdr_err          pulse per invalid header (00/11) while locked
//   frame_err        pulse per framing violation
// Optional (macro AURORA_RX_ERR_CNT_EN):
//   err_cnt_clr      clears both error counters (wins over increment)
//   hdr_err_cnt      saturating count of hdr_err pulses
//   frame_err_cnt    saturating count of frame_err pulses
module aurora_rx_lane #(
  parameter int ENCODED_DATA_SIZE = 66,
  parameter int AXI_DATA_SIZE     = 64,
  parameter int LOCK_CNT          = 64,
  parameter int UNLOCK_ERR        = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enc_valid,
  input  logic [ENCODED_DATA_SIZE-1:0] enc_data,
  output logic                         axi_valid,
  output logic                         axi_last,
  output logic [7:0]                   axi_keep,
  output logic [AXI_DATA_SIZE-1:0]     axi_data,
  output logic                         block_lock,
  output logic                         hdr_err,
  output logic                         frame_err
`ifdef AURORA_RX_ERR_CNT_EN
  ,
  input  logic                         err_cnt_clr,
  output logic [15:0]                  hdr_err_cnt,
  output logic [15:0]                  frame_err_cnt
`endif
);

  localparam int PW  = ENCODED_DATA_SIZE - 2;
  localparam int SW  = 58;
  localparam int TAP = SW - 39;
  localparam int CW  = $clog2(LOCK_CNT);
  localparam int EW  = $clog2(UNLOCK_ERR + 1);

  typedef enum logic {HUNT, LOCK} state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d, win_q, win_d;
  logic [EW-1:0]            err_q, err_d, err_n;
  logic [SW-1:0]            scr_q, scr_d;
  logic [PW-1:0]            hold_q, hold_d;
  logic                     hold_full_q, hold_full_d;
  logic                     in_frame_q, in_frame_d;
  logic                     pend_valid_q, pend_valid_d;
  logic [AXI_DATA_SIZE-1:0] pend_data_q, pend_data_d;
  logic [7:0]               pend_keep_q, pend_keep_d;
  logic                     valid_q, valid_d, last_q, last_d;
  logic [7:0]               keep_q, keep_d;
  logic [AXI_DATA_SIZE-1:0] data_q, data_d;
  logic                     hdr_err_q, hdr_err_d, frame_err_q, frame_err_d;

  logic [1:0]       hdr;
  logic [PW-1:0]    payload, desc;
  logic [PW+SW-1:0] ext;
  logic             hdr_bad, lock_lost;
  logic [7:0]       sep_n, keep_n;

  assign hdr     = enc_data[ENCODED_DATA_SIZE-1 -: 2];
  assign payload = enc_data[PW-1:0];
  assign hdr_bad = (hdr == 2'b00) || (hdr == 2'b11);
  assign sep_n   = desc[15:8];
  assign keep_n  = ~(8'hFF << sep_n[2:0]);

  function automatic logic [AXI_DATA_SIZE-1:0] keep_mask(input logic [7:0] k);
    logic [AXI_DATA_SIZE-1:0] m;
    m = '0;
    for (int unsigned b = 0; b < 8; b++) m[8*b +: 8] = {8{k[b]}};
    return m;
  endfunction

  // ext places the current payload above the 58 previously received bits,
  // so ext[i] is stream bit i-58 and ext[i+TAP] is stream bit i-39.
  always_comb begin
    ext  = {payload, scr_q};
    desc = '0;
    for (int unsigned i = 0; i < PW; i++) desc[i] = payload[i] ^ ext[i+TAP] ^ ext[i];
    scr_d = enc_valid ? payload[PW-1 -: SW] : scr_q;
  end

  // Lock FSM next-state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    err_d     = err_q;
    err_n     = err_q;
    lock_lost = 1'b0;
    if (enc_valid) begin
      unique case (state_q)
        HUNT: begin
          if (hdr_bad) begin
            cnt_d = '0;
          end else if (cnt_q == CW'(LOCK_CNT - 1)) begin
            state_d = LOCK;
            cnt_d   = '0;
            win_d   = '0;
            err_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        LOCK: begin
          win_d = (win_q == CW'(LOCK_CNT - 1)) ? '0 : win_q + 1'b1;
          err_n = hdr_bad ? err_q + 1'b1 : err_q;
          // The error on the wrap block is counted before the window clear.
          if (err_n == EW'(UNLOCK_ERR)) begin
            state_d   = HUNT;
            lock_lost = 1'b1;
            cnt_d     = '0;
            win_d     = '0;
            err_d     = '0;
          end else if (win_q == CW'(LOCK_CNT - 1)) begin
            err_d = '0;
          end else begin
            err_d = err_n;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Decode and output generation
  always_comb begin
    valid_d      = 1'b0;
    last_d       = 1'b0;
    keep_d       = '0;
    data_d       = '0;
    hdr_err_d    = 1'b0;
    frame_err_d  = 1'b0;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    in_frame_d   = in_frame_q;
    pend_valid_d = 1'b0;
    pend_data_d  = pend_data_q;
    pend_keep_d  = pend_keep_q;
    block_lock   = (state_q == LOCK);
    // A pending tail beat never overlaps a hold emit: the separator that
    // created it also emptied the hold register.
    if (pend_valid_q) begin
      valid_d = 1'b1;
      last_d  = 1'b1;
      keep_d  = pend_keep_q;
      data_d  = pend_data_q;
    end
    if (enc_valid && state_q == LOCK) begin
      if (hdr_bad) begin
        hdr_err_d = 1'b1;
        if (lock_lost) begin
          frame_err_d  = in_frame_q;
          hold_full_d  = 1'b0;
          pend_valid_d = 1'b0;
          in_frame_d   = 1'b0;
        end
      end else if (hdr == 2'b01) begin
        if (hold_full_q) begin
          valid_d = 1'b1;
          keep_d  = 8'hFF;
          data_d  = hold_q;
        end
        hold_d      = desc;
        hold_full_d = 1'b1;
        in_frame_d  = 1'b1;
      end else begin
        case (desc[7:0])
          8'h1E: begin
            if (sep_n > 8'd6) begin
              frame_err_d = 1'b1;
            end else begin
              if (hold_full_q) begin
                valid_d = 1'b1;
                keep_d  = 8'hFF;
                last_d  = (sep_n == 8'd0);
                data_d  = hold_q;
              end else if (sep_n == 8'd0) begin
                frame_err_d = 1'b1;
              end
              if (sep_n != 8'd0) begin
                pend_valid_d = 1'b1;
                pend_keep_d  = keep_n;
                pend_data_d  = (desc >> 16) & keep_mask(keep_n);
              end
              hold_full_d = 1'b0;
              in_frame_d  = 1'b0;
            end
          end
          8'hE1: begin
            if (hold_full_q) begin
              valid_d = 1'b1;
              keep_d  = 8'hFF;
              data_d  = hold_q;
            end
            pend_valid_d = 1'b1;
            pend_keep_d  = 8'h7F;
            pend_data_d  = desc >> 8;
            hold_full_d  = 1'b0;
            in_frame_d   = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      cnt_q        <= '0;
      win_q        <= '0;
      err_q        <= '0;
      scr_q        <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      in_frame_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      pend_keep_q  <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      keep_q       <= '0;
      data_q       <= '0;
      hdr_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      win_q        <= win_d;
      err_q        <= err_d;
      scr_q        <= scr_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      in_frame_q   <= in_frame_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      pend_keep_q  <= pend_keep_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      keep_q       <= keep_d;
      data_q       <= data_d;
      hdr_err_q    <= hdr_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign axi_valid = valid_q;
  assign axi_last  = last_q;
  assign axi_keep  = keep_q;
  assign axi_data  = data_q;
  assign hdr_err   = hdr_err_q;
  assign frame_err = frame_err_q;

`ifdef AURORA_RX_ERR_CNT_EN
  logic [15:0] hdr_err_cnt_q, hdr_err_cnt_d, frame_err_cnt_q, frame_err_cnt_d;

  always_comb begin
    hdr_err_cnt_d   = hdr_err_cnt_q;
    frame_err_cnt_d = frame_err_cnt_q;
    if (err_cnt_clr) begin
      hdr_err_cnt_d   = '0;
      frame_err_cnt_d = '0;
    end else begin
      if (hdr_err_d && hdr_err_cnt_q != '1)     hdr_err_cnt_d   = hdr_err_cnt_q + 1'b1;
      if (frame_err_d && frame_err_cnt_q != '1) frame_err_cnt_d = frame_err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_err_cnt_q   <= '0;
      frame_err_cnt_q <= '0;
    end else begin
      hdr_err_cnt_q   <= hdr_err_cnt_d;
      frame_err_cnt_q <= frame_err_cnt_d;
    end
  end

  assign hdr_err_cnt   = hdr_err_cnt_q;
  assign frame_err_cnt = frame_err_cnt_q;
`endif

endmodule

// File: tb/tb_aurora_rx_lane.sv
// Directed testbench for aurora_rx_lane. Stimulus passes through a bit-serial
// reference scrambler seeded 0; expected beats are hand-computed constants.
module tb_aurora_rx_lane;

  logic        clk = 1'b0;
  logic        rst;
  logic        enc_valid;
  logic [65:0] enc_data;
  logic        axi_valid, axi_last, block_lock, hdr_err, frame_err;
  logic [7:0]  axi_keep;
  logic [63:0] axi_data;
`ifdef AURORA_RX_ERR_CNT_EN
  logic        err_cnt_clr;
  logic [15:0] hdr_err_cnt, frame_err_cnt;
`endif

  always #5 clk = ~clk;

  aurora_rx_lane #(
    .ENCODED_DATA_SIZE(66),
    .AXI_DATA_SIZE(64),
    .LOCK_CNT(64),
    .UNLOCK_ERR(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enc_valid(enc_valid),
    .enc_data(enc_data),
    .axi_valid(axi_valid),
    .axi_last(axi_last),
    .axi_keep(axi_keep),
    .axi_data(axi_data),
    .block_lock(block_lock),
    .hdr_err(hdr_err),
    .frame_err(frame_err)
`ifdef AURORA_RX_ERR_CNT_EN
    ,
    .err_cnt_clr(err_cnt_clr),
    .hdr_err_cnt(hdr_err_cnt),
    .frame_err_cnt(frame_err_cnt)
`endif
  );

  localparam logic [63:0] IDLE = 64'h0000_0000_0000_0078;
  localparam logic [63:0] D0   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D1   = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] D2   = 64'hDEAD_BEEF_CAFE_F00D;

  int checks = 0;
  int errors = 0;
  int locked_blocks = 0;
  logic [57:0] scr_st = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // st[0] is the most recent scrambled bit, st[38] is 39 back, st[57] is 58 back.
  task automatic scramble(input logic [63:0] d, output logic [63:0] s);
    logic o;
    for (int i = 0; i < 64; i++) begin
      o      = d[i] ^ scr_st[38] ^ scr_st[57];
      s[i]   = o;
      scr_st = {scr_st[56:0], o};
    end
  endtask

  task automatic send(input logic [1:0] h, input logic [63:0] pl);
    logic [63:0] s;
    scramble(pl, s);
    @(negedge clk);
    enc_valid = 1'b1;
    enc_data  = {h, s};
    @(posedge clk);
    #1;
    locked_blocks++;
  endtask

  task automatic expect_beat(input string tag, input logic [7:0] keep, input logic last,
                             input logic [63:0] data);
    check_eq({tag, "_valid"}, 64'(axi_valid), 64'd1);
    check_eq({tag, "_keep"}, 64'(axi_keep), 64'(keep));
    check_eq({tag, "_last"}, 64'(axi_last), 64'(last));
    check_eq({tag, "_data"}, axi_data, data);
  endtask

  task automatic expect_quiet(input string tag);
    check_eq({tag, "_valid"}, 64'(axi_valid), 64'd0);
  endtask

  task automatic lock_up(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      send(2'b10, IDLE);
      seen = seen | axi_valid | hdr_err;
      if (i == 1)  check_eq({tag, "_ferr0"}, 64'(frame_err), 64'd0);
      if (i == 63) check_eq({tag, "_prelock"}, 64'(block_lock), 64'd0);
    end
    check_eq({tag, "_lock"}, 64'(block_lock), 64'd1);
    check_eq({tag, "_quiet"}, 64'(seen), 64'd0);
    locked_blocks = 0;
  endtask

  task automatic pad_to_window;
    while (locked_blocks % 64 != 0) send(2'b10, IDLE);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    enc_valid = 1'b0;
    enc_data  = '0;
`ifdef AURORA_RX_ERR_CNT_EN
    err_cnt_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 64'(axi_valid), 64'd0);
    check_eq("rst_last", 64'(axi_last), 64'd0);
    check_eq("rst_keep", 64'(axi_keep), 64'd0);
    check_eq("rst_data", axi_data, 64'd0);
    check_eq("rst_lock", 64'(block_lock), 64'd0);
    check_eq("rst_herr", 64'(hdr_err), 64'd0);
    check_eq("rst_ferr", 64'(frame_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: acquire lock on 64 idles
    lock_up("t1");

    // 2: three data beats closed by N=0 separator
    send(2'b01, D0);   expect_quiet("t2_d0");
    send(2'b01, D1);   expect_beat("t2_b0", 8'hFF, 1'b0, D0);
    send(2'b01, D2);   expect_beat("t2_b1", 8'hFF, 1'b0, D1);
    send(2'b10, 64'h001E); expect_beat("t2_b2", 8'hFF, 1'b1, D2);
    send(2'b10, IDLE); expect_quiet("t2_end");

    // 3: separator N=3; trailing garbage bytes must be masked
    send(2'b01, D0);   expect_quiet("t3_d0");
    send(2'b01, D1);   expect_beat("t3_b0", 8'hFF, 1'b0, D0);
    send(2'b10, 64'h3322_11CC_BBAA_031E); expect_beat("t3_b1", 8'hFF, 1'b0, D1);
    send(2'b10, IDLE); expect_beat("t3_b2", 8'h07, 1'b1, 64'h0000_0000_00CC_BBAA);
    send(2'b10, IDLE); expect_quiet("t3_end");

    // separator-7 tail
    send(2'b01, D2);   expect_quiet("t7_d2");
    send(2'b10, 64'h7766_5544_3322_11E1); expect_beat("t7_b0", 8'hFF, 1'b0, D2);
    send(2'b10, IDLE); expect_beat("t7_b1", 8'h7F, 1'b1, 64'h0077_6655_4433_2211);

    // unknown control type leaves hold untouched
    send(2'b01, D0);   expect_quiet("tc_d0");
    send(2'b10, 64'h004B); expect_quiet("tc_ctl");
    send(2'b10, 64'h001E); expect_beat("tc_b0", 8'hFF, 1'b1, D0);

    // 5: framing violations on an idle line
    send(2'b10, 64'h001E);
    check_eq("t5_n0_ferr", 64'(frame_err), 64'd1);
    expect_quiet("t5_n0");
    send(2'b10, IDLE);
    check_eq("t5_pulse", 64'(frame_err), 64'd0);
    send(2'b10, 64'h071E);
    check_eq("t5_n7_ferr", 64'(frame_err), 64'd1);
    expect_quiet("t5_n7");
    send(2'b10, IDLE);
    check_eq("t5_n7_end", 64'(frame_err), 64'd0);

    // 4: 16 header errors inside one window, mid-frame
    pad_to_window();
    send(2'b01, D0);   expect_quiet("t4_d0");
    for (int i = 1; i <= 16; i++) begin
      send((i % 2 == 1) ? 2'b11 : 2'b00, 64'h0);
      check_eq("t4_herr", 64'(hdr_err), 64'd1);
      check_eq("t4_lock", 64'(block_lock), 64'(i < 16));
      check_eq("t4_ferr", 64'(frame_err), 64'(i == 16));
      check_eq("t4_last", 64'(axi_last), 64'd0);
      expect_quiet("t4_bad");
    end
    lock_up("t4r");

    // 15 errors early, 16th on the window-wrap block still drops lock
    pad_to_window();
    for (int i = 0; i < 15; i++) begin
      send(2'b00, 64'h0);
      check_eq("tw_herr", 64'(hdr_err), 64'd1);
    end
    while (locked_blocks % 64 != 63) send(2'b10, IDLE);
    check_eq("tw_prelock", 64'(block_lock), 64'd1);
    send(2'b11, 64'h0);
    check_eq("tw_herr16", 64'(hdr_err), 64'd1);
    check_eq("tw_unlock", 64'(block_lock), 64'd0);
    check_eq("tw_ferr", 64'(frame_err), 64'd0);
    lock_up("twr");

    // 6: reset mid-frame, relock, clean 2-beat frame
    send(2'b01, D0);   expect_quiet("t6_d0");
    @(negedge clk);
    rst       = 1'b1;
    enc_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t6_rst_valid", 64'(axi_valid), 64'd0);
    check_eq("t6_rst_lock", 64'(block_lock), 64'd0);
    check_eq("t6_rst_data", axi_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    lock_up("t6r");
    send(2'b01, D1);   expect_quiet("t6_d1");
    send(2'b01, D2);   expect_beat("t6_b0", 8'hFF, 1'b0, D1);
    send(2'b10, 64'h001E); expect_beat("t6_b1", 8'hFF, 1'b1, D2);

`ifdef AURORA_RX_ERR_CNT_EN
    check_eq("cnt_rst_f", 64'(frame_err_cnt), 64'd0);
    err_cnt_clr = 1'b1;
    send(2'b10, 64'h071E);
    check_eq("cnt_clr_wins", 64'(frame_err_cnt), 64'd0);
    err_cnt_clr = 1'b0;
    send(2'b10, 64'h071E);
    check_eq("cnt_one", 64'(frame_err_cnt), 64'd1);
    for (int i = 0; i < 65535; i++) send(2'b10, 64'h071E);
    check_eq("cnt_sat", 64'(frame_err_cnt), 64'hFFFF);
    send(2'b00, 64'h0);
    check_eq("cnt_hdr", 64'(hdr_err_cnt), 64'd1);
    err_cnt_clr = 1'b1;
    send(2'b00, 64'h0);
    check_eq("cnt_hdr_clr", 64'(hdr_err_cnt), 64'd0);
    check_eq("cnt_f_clr", 64'(frame_err_cnt), 64'd0);
    err_cnt_clr = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
